// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings and the DMA read-master state type.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } HBURST_Type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ABORT = 3'd3,
        ST_DONE  = 3'd4
    } dma_rd_state;

endpackage

// File: rtl/ahb_burst_planner.sv
// Decides how the next address beat is issued: continue the burst (SEQ) or
// open a new one (NONSEQ), and which HBURST a newly opened burst advertises.
module ahb_burst_planner
    import ahb3lite_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5,
    parameter int WORDS_W   = 15
) (
    input  logic [7:0]         i_word_idx,    // address bits [9:2] of the beat
    input  logic [WORDS_W-1:0] i_words_left,  // words still to issue, this one included
    input  logic [CNT_W-1:0]   i_beat_cnt,    // beats already issued in the burst (0 = none)
    output HTRANS_state        o_htrans,
    output HBURST_Type         o_hburst,
    output logic               o_boundary
);

    logic new_burst;
    logic one_beat;

    // A new burst opens at start, at the beat cap, or on a 1 KB boundary; it is
    // a single beat when only one word remains or it sits on the last word before 1 KB.
    always_comb begin
        o_boundary = (i_word_idx == 8'd0);
        new_burst  = (i_beat_cnt == '0) || (i_beat_cnt == CNT_W'(MAX_BEATS)) || o_boundary;
        one_beat   = (i_words_left == WORDS_W'(1)) || (i_word_idx == 8'hFF);
        o_htrans   = new_burst ? NONSEQ : SEQ;
        o_hburst   = one_beat ? SINGLE : INCR;
    end

endmodule

// File: rtl/ahb_dma_read_master.sv
// AHB-Lite read-only DMA master: fetches ceil(len/4) words from an ascending
// word address with pipelined INCR bursts and streams them to a local sink.
module ahb_dma_read_master
    import ahb3lite_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_start,
    input  logic [31:0]       i_src_addr,
    input  logic [LEN_W-1:0]  i_len_bytes,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [LEN_W-2:0]  o_beats_done,
    input  logic              HREADY,
    input  HRESP_state        HRESP,
    input  logic [31:0]       HRDATA,
    output logic [31:0]       HADDR,
    output HBURST_Type        HBURST,
    output logic [2:0]        HSIZE,
    output HTRANS_state       HTRANS,
    output logic              HWRITE,
    output logic [31:0]       o_rdata,
    output logic              o_rvalid
);

    localparam int CNT_W   = $clog2(MAX_BEATS) + 1;
    localparam int WORDS_W = LEN_W - 1;

    dma_rd_state        state_q, state_d;
    logic [31:0]        haddr_q, haddr_d;
    HTRANS_state        htrans_q, htrans_d;
    HBURST_Type         hburst_q, hburst_d;
    logic [WORDS_W-1:0] issue_left_q, issue_left_d;  // addresses not yet accepted
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;      // beats issued in current burst
    logic               dphase_q, dphase_d;          // a data phase is outstanding
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [WORDS_W-1:0] beats_done_q, beats_done_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [31:0]        start_addr;
    logic [WORDS_W-1:0] start_words;
    logic [31:0]        next_addr;
    logic [7:0]         plan_idx;
    logic [WORDS_W-1:0] plan_words;
    logic [CNT_W-1:0]   plan_cnt;
    HTRANS_state        plan_htrans;
    HBURST_Type         plan_hburst;
    logic               plan_boundary;
    logic               data_ok;
    logic               data_err_wait;
    logic               data_err_last;

    // Command decode and planner input selection (fresh command vs. next beat).
    always_comb begin
        start_addr  = i_src_addr & 32'hFFFF_FFFC;
        start_words = WORDS_W'(({1'b0, i_len_bytes} + (LEN_W + 1)'(3)) >> 2);
        next_addr   = haddr_q + 32'd4;
        if (state_q == ST_IDLE) begin
            plan_idx   = start_addr[9:2];
            plan_words = start_words;
            plan_cnt   = '0;
        end else begin
            plan_idx   = next_addr[9:2];
            plan_words = issue_left_q - WORDS_W'(1);
            plan_cnt   = beat_cnt_q;
        end
    end

    ahb_burst_planner #(
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W),
        .WORDS_W   (WORDS_W)
    ) u_planner (
        .i_word_idx   (plan_idx),
        .i_words_left (plan_words),
        .i_beat_cnt   (plan_cnt),
        .o_htrans     (plan_htrans),
        .o_hburst     (plan_hburst),
        .o_boundary   (plan_boundary)
    );

    // Next-state logic: address pipeline, data capture and abort handling.
    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hburst_d     = hburst_q;
        issue_left_d = issue_left_q;
        beat_cnt_d   = beat_cnt_q;
        dphase_d     = dphase_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        beats_done_d = beats_done_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;

        data_ok       = dphase_q && HREADY && (HRESP == OKAY) && (state_q != ST_ABORT);
        data_err_wait = dphase_q && !HREADY && (HRESP == ERROR);
        data_err_last = dphase_q && HREADY && (HRESP == ERROR);

        if (data_ok) begin
            rvalid_d     = 1'b1;
            rdata_d      = HRDATA;
            beats_done_d = beats_done_q + WORDS_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    error_d      = 1'b0;
                    beats_done_d = '0;
                    busy_d       = 1'b1;
                    if (start_words != '0) begin
                        haddr_d      = start_addr;
                        htrans_d     = NONSEQ;
                        hburst_d     = plan_hburst;
                        issue_left_d = start_words;
                        beat_cnt_d   = CNT_W'(1);
                        state_d      = ST_XFER;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_XFER: begin
                if (data_err_wait) begin
                    // Withdraw the pending address; the error's second cycle is awaited.
                    htrans_d = IDLE;
                    state_d  = ST_ABORT;
                end else if (data_err_last) begin
                    htrans_d = IDLE;
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    dphase_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (HREADY) begin
                    dphase_d = 1'b1;
                    if (issue_left_q == WORDS_W'(1)) begin
                        htrans_d = IDLE;
                        state_d  = ST_DRAIN;
                    end else begin
                        haddr_d      = next_addr;
                        issue_left_d = issue_left_q - WORDS_W'(1);
                        htrans_d     = plan_htrans;
                        if (plan_htrans == NONSEQ) begin
                            hburst_d   = plan_hburst;
                            beat_cnt_d = CNT_W'(1);
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (data_err_wait) begin
                    state_d = ST_ABORT;
                end else if (data_err_last || data_ok) begin
                    error_d  = data_err_last ? 1'b1 : error_q;
                    done_d   = 1'b1;
                    dphase_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_ABORT: begin
                if (HREADY) begin
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    dphase_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            haddr_q      <= '0;
            htrans_q     <= IDLE;
            hburst_q     <= SINGLE;
            issue_left_q <= '0;
            beat_cnt_q   <= '0;
            dphase_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            beats_done_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hburst_q     <= hburst_d;
            issue_left_q <= issue_left_d;
            beat_cnt_q   <= beat_cnt_d;
            dphase_q     <= dphase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            beats_done_q <= beats_done_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign HADDR        = haddr_q;
    assign HTRANS       = htrans_q;
    assign HBURST       = hburst_q;
    assign HSIZE        = HSIZE_WORD;
    assign HWRITE       = 1'b0;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_beats_done = beats_done_q;
    assign o_rdata      = rdata_q;
    assign o_rvalid     = rvalid_q;

endmodule

// File: tb/tb_ahb_dma_read_master.sv
// Directed bench: a scripted AHB slave inside the stimulus process, with
// expected address beats and read words queued per command.
module tb_ahb_dma_read_master;
    import ahb3lite_pkg::*;

    localparam int LEN_W     = 16;
    localparam int MAX_BEATS = 4;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              i_start;
    logic [31:0]       i_src_addr;
    logic [LEN_W-1:0]  i_len_bytes;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [LEN_W-2:0]  o_beats_done;
    logic              HREADY;
    HRESP_state        HRESP;
    logic [31:0]       HRDATA;
    logic [31:0]       HADDR;
    HBURST_Type        HBURST;
    logic [2:0]        HSIZE;
    HTRANS_state       HTRANS;
    logic              HWRITE;
    logic [31:0]       o_rdata;
    logic              o_rvalid;

    int tests = 0;
    int fails = 0;

    logic [36:0] exp_addr_q[$];  // {htrans, hburst, haddr}
    logic [31:0] exp_data_q[$];

    always #5 HCLK = ~HCLK;

    ahb_dma_read_master #(
        .LEN_W     (LEN_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .i_start      (i_start),
        .i_src_addr   (i_src_addr),
        .i_len_bytes  (i_len_bytes),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_beats_done (o_beats_done),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA),
        .HADDR        (HADDR),
        .HBURST       (HBURST),
        .HSIZE        (HSIZE),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the first n_acc address beats of an n_all-word command, bursts
    // capped by MAX_BEATS and the 1 KB boundary, plus the first n_data words.
    task automatic plan(input logic [31:0] base, input int n_acc, input int n_all,
                        input int n_data);
        int          cnt;
        int          blen;
        int          room;
        logic [31:0] a;
        logic [1:0]  tr;
        logic [2:0]  bu;
        cnt = 0;
        bu  = 3'd0;
        for (int i = 0; i < n_acc; i++) begin
            a = base + 32'(4 * i);
            if (i == 0 || cnt == MAX_BEATS || a[9:0] == 10'd0) begin
                blen = n_all - i;
                if (blen > MAX_BEATS) blen = MAX_BEATS;
                room = (1024 - int'(a[9:0])) / 4;
                if (blen > room) blen = room;
                bu  = (blen == 1) ? 3'd0 : 3'd1;
                tr  = 2'b10;
                cnt = 0;
            end else begin
                tr = 2'b11;
            end
            cnt++;
            exp_addr_q.push_back({tr, bu, a});
        end
        for (int i = 0; i < n_data; i++) exp_data_q.push_back(data_of(base + 32'(4 * i)));
    endtask

    // Issue one command and act as the slave until o_done, checking every
    // accepted address beat, every returned word and the completion status.
    task automatic run_cmd(input string name, input logic [31:0] addr,
                           input logic [LEN_W-1:0] len, input int stall_beat, input int stall_n,
                           input int err_beat, input logic exp_err, input int exp_beats,
                           input int exp_done_cyc);
        int          cyc;
        int          acc;
        int          last_acc;
        int          done_cyc;
        int          st_cnt;
        int          err_ph;
        logic        dp_v;
        logic [31:0] dp_a;
        int          dp_i;
        logic        nx_v;
        logic [31:0] nx_a;
        int          nx_i;
        logic        prev_stall;
        logic [31:0] prev_haddr;
        logic [1:0]  prev_htrans;
        logic [36:0] e;
        acc = 0; last_acc = -1; done_cyc = -1; st_cnt = 0; err_ph = 0;
        dp_v = 1'b0; dp_a = '0; dp_i = -1; prev_stall = 1'b0;
        prev_haddr = '0; prev_htrans = '0;
        i_src_addr  = addr;
        i_len_bytes = len;
        i_start     = 1'b1;
        @(posedge HCLK); #1;
        i_start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 20000) begin
            if (o_rvalid) begin
                check({name, "_rvalid_expected"}, exp_data_q.size() > 0, 1'b1);
                if (exp_data_q.size() > 0) check({name, "_rdata"}, o_rdata, exp_data_q.pop_front());
            end
            if (o_done) begin
                done_cyc = cyc;
                check({name, "_error"}, o_error, exp_err);
                check({name, "_beats_done"}, o_beats_done, exp_beats);
                check({name, "_busy_at_done"}, o_busy, 1'b1);
            end
            if (prev_stall) begin
                check({name, "_haddr_hold"}, HADDR, prev_haddr);
                check({name, "_htrans_hold"}, HTRANS, prev_htrans);
            end
            HREADY = 1'b1;
            HRESP  = OKAY;
            prev_stall = 1'b0;
            if (dp_v && dp_i == err_beat) begin
                if (err_ph == 0) begin
                    HREADY = 1'b0;
                    HRESP  = ERROR;
                    err_ph = 1;
                end else begin
                    HRESP = ERROR;
                    check({name, "_htrans_cancel"}, HTRANS, IDLE);
                end
            end else if (dp_v && dp_i == stall_beat && st_cnt < stall_n) begin
                HREADY      = 1'b0;
                st_cnt++;
                prev_stall  = 1'b1;
                prev_haddr  = HADDR;
                prev_htrans = HTRANS;
            end
            HRDATA = dp_v ? data_of(dp_a) : 32'h0;
            nx_v = dp_v; nx_a = dp_a; nx_i = dp_i;
            if (HREADY) begin
                nx_v = (HTRANS == NONSEQ) || (HTRANS == SEQ);
                if (nx_v) begin
                    check({name, "_accept_expected"}, exp_addr_q.size() > 0, 1'b1);
                    if (exp_addr_q.size() > 0) begin
                        e = exp_addr_q.pop_front();
                        check({name, "_htrans"}, HTRANS, e[36:35]);
                        check({name, "_hburst"}, HBURST, e[34:32]);
                        check({name, "_haddr"}, HADDR, e[31:0]);
                    end
                    nx_a = HADDR;
                    nx_i = acc;
                    acc++;
                    last_acc = cyc;
                end
            end
            @(posedge HCLK); #1;
            cyc++;
            dp_v = nx_v; dp_a = nx_a; dp_i = nx_i;
        end
        HREADY = 1'b1;
        HRESP  = OKAY;
        check({name, "_done_seen"}, done_cyc >= 0, 1'b1);
        if (exp_done_cyc >= 0) check({name, "_done_cycle"}, done_cyc, exp_done_cyc);
        if (last_acc >= 0 && !exp_err) check({name, "_done_after_last"}, done_cyc - last_acc, 2);
        check({name, "_addr_q_empty"}, exp_addr_q.size(), 0);
        check({name, "_data_q_empty"}, exp_data_q.size(), 0);
        check({name, "_busy_after"}, o_busy, 1'b0);
        check({name, "_done_one_cycle"}, o_done, 1'b0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        HRESETn     = 1'b0;
        i_start     = 1'b0;
        i_src_addr  = '0;
        i_len_bytes = '0;
        HREADY      = 1'b1;
        HRESP       = OKAY;
        HRDATA      = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_htrans", HTRANS, IDLE);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hburst", HBURST, SINGLE);
        check("rst_hsize", HSIZE, 3'b010);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_beats", o_beats_done, 0);
        check("rst_rvalid", o_rvalid, 1'b0);
        check("rst_rdata", o_rdata, 32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        plan(32'h1000, 4, 4, 4);
        run_cmd("incr4", 32'h1000, 16'd16, -1, 0, -1, 1'b0, 4, 6);

        plan(32'h13F8, 4, 4, 4);
        run_cmd("kb_split", 32'h13F8, 16'd16, -1, 0, -1, 1'b0, 4, 6);

        plan(32'h13FC, 2, 2, 2);
        run_cmd("kb_single", 32'h13FF, 16'd8, -1, 0, -1, 1'b0, 2, 4);

        plan(32'h2000, 10, 10, 10);
        run_cmd("beat_cap", 32'h2000, 16'd40, -1, 0, -1, 1'b0, 10, 12);

        plan(32'h2100, 2, 2, 2);
        run_cmd("len5", 32'h2100, 16'd5, -1, 0, -1, 1'b0, 2, 4);

        plan(32'h2200, 1, 1, 1);
        run_cmd("len1", 32'h2200, 16'd1, -1, 0, -1, 1'b0, 1, 3);

        run_cmd("len0", 32'h2300, 16'd0, -1, 0, -1, 1'b0, 0, 1);

        plan(32'h4000, 4, 4, 4);
        run_cmd("stall", 32'h4000, 16'd16, 1, 3, -1, 1'b0, 4, 9);

        plan(32'h3000, 3, 8, 2);
        run_cmd("error", 32'h3000, 16'd32, -1, 0, 2, 1'b1, 2, 6);

        plan(32'h0, 16384, 16384, 16384);
        run_cmd("maxlen", 32'h0, 16'hFFFF, -1, 0, -1, 1'b0, 16384, 16386);

        // Reset in the middle of a burst with non-zero captured data.
        HRDATA      = 32'hCAFE_F00D;
        i_src_addr  = 32'h5000;
        i_len_bytes = 16'd32;
        i_start     = 1'b1;
        @(posedge HCLK); #1;
        i_start = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("midrst_busy_before", o_busy, 1'b1);
        HRESETn = 1'b0;
        #1;
        check("midrst_htrans", HTRANS, IDLE);
        check("midrst_haddr", HADDR, 32'h0);
        check("midrst_hburst", HBURST, SINGLE);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_beats", o_beats_done, 0);
        check("midrst_rvalid", o_rvalid, 1'b0);
        check("midrst_rdata", o_rdata, 32'h0);
        check("midrst_done", o_done, 1'b0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        plan(32'h6000, 1, 1, 1);
        run_cmd("after_rst", 32'h6000, 16'd4, -1, 0, -1, 1'b0, 1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_dma_read_master.md
Name: ahb_dma_read_master

Overview:
Parametrised AHB-Lite read-only DMA master: the next generation of the core-system DMA master.
- Fetches a byte-length buffer from an ascending word address and streams the returned words to the local sink.
- Transfers are pipelined, with address and data phases overlapped.
- Generalises the previous block with a wide length counter, configurable burst cap, 1 KB-boundary burst splitting, wait-state tolerance and ERROR-response abort.
- Sits between the CPU register block (command/status) and the AHB-Lite interconnect.

Parameters:
LEN_W, 16, width of byte-length command field (max buffer 2^LEN_W-1 bytes)
MAX_BEATS, 16, maximum beats per INCR burst before a fresh NONSEQ is issued (power of two, 2..256)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
i_start  in  1  command strobe, sampled when o_busy=0
i_src_addr  in  32  source byte address; bits [1:0] forced to 0
i_len_bytes  in  LEN_W  buffer length in bytes
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse at command end (success or error)
o_error  out  1  sticky error flag, cleared on next accepted i_start
o_beats_done  out  LEN_W-1  words received for current command
HREADY  in  1  slave ready
HRESP  in  HRESP_state  slave response (OKAY/ERROR)
HRDATA  in  32  read data
HADDR  out  32  address
HBURST  out  HBURST_Type  SINGLE or INCR
HSIZE  out  3  always WORD
HTRANS  out  HTRANS_state  IDLE/NONSEQ/SEQ
HWRITE  out  1  always READ (0)
o_rdata  out  32  registered read word
o_rvalid  out  1  o_rdata valid, one-cycle per word

Behaviour:
- Clock and reset: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=WORD, HWRITE=0, o_busy=0, o_done=0, o_error=0, o_beats_done=0, o_rdata=0, o_rvalid=0.
  - Reset mid-transfer aborts immediately; there is no cleanup cycle.
- Word count: N = ceil(i_len_bytes/4), i.e. (len+3)>>2 at LEN_W+1 bits.
- All AHB outputs are registered.
- Addresses ascend by 4 per beat.
- States:
  - IDLE
  - XFER: address phase active; the data phase of the previous beat may overlap.
  - DRAIN: last address accepted; HTRANS=IDLE; waiting on the final data phase.
  - ABORT: ERROR seen; HTRANS=IDLE; waiting on HREADY=1.
  - DONE: one cycle; pulses o_done, then returns to IDLE.
- IDLE transitions:
  - i_start=1 and N>0: latch address and N, clear o_error and o_beats_done, set o_busy; next cycle HTRANS=NONSEQ, HADDR=addr → XFER.
  - i_start=1 and N=0: → DONE with no bus activity; o_done is asserted one cycle after i_start.
  - i_start while o_busy=1 is ignored.
- Address acceptance: an address is accepted on a cycle with HTRANS∈{NONSEQ,SEQ} and HREADY=1. While HREADY=0, HADDR/HTRANS/HBURST are held.
- Next beat after an acceptance:
  - Address +4.
  - HTRANS=NONSEQ if the beat-in-burst count has reached MAX_BEATS, or if the new address has [9:0]=0 (1 KB boundary). Otherwise HTRANS=SEQ.
  - A burst never crosses 1 KB.
- HBURST per burst: SINGLE if the remaining words ≥1 but the burst will be exactly one beat; otherwise INCR. Computed when NONSEQ is issued.
- Last address: when the last of N addresses is accepted, → DRAIN with HTRANS=IDLE.
- Data phase:
  - Completes on HREADY=1 with HRESP=OKAY.
  - Next cycle: o_rvalid=1, o_rdata=HRDATA, o_beats_done+1.
  - Sink has no backpressure.
- DRAIN exit: final data completion → DONE.
- ERROR response:
  - HRESP=ERROR with HREADY=0 during a data phase: register HTRANS=IDLE (cancel the pending address) → ABORT.
  - In ABORT, on HREADY=1: set o_error=1 → DONE. The errored beat produces no o_rvalid.
- DONE: o_done=1 for one cycle, o_busy=0 on the following cycle.
- Boundary conditions:
  - N=1 gives SINGLE/NONSEQ then DRAIN.
  - Length wrap: i_len_bytes max value yields N=2^(LEN_W-2) words; counters must not overflow.
  - Address wrap past 0xFFFFFFFC is not supported (no check).

Decomposition:
- ahb3lite_pkg keeps HTRANS_state, HBURST_Type, HRESP_state and the HSIZE WORD constant. Add a dma_rd_state enum (IDLE, XFER, DRAIN, ABORT, DONE) to the package.
- One natural sub-module: ahb_burst_planner, combinational. It takes the current address, remaining words and beat-in-burst count, and returns next HTRANS, HBURST and the boundary flag.

Test Plan:
- addr=0x1000, len=16, HREADY=1 always → NONSEQ INCR @0x1000, SEQ 0x1004/0x1008/0x100C; 4 o_rvalid pulses; o_done 2 cycles after last acceptance; o_error=0.
- addr=0x13F8, len=16 → NONSEQ 0x13F8, SEQ 0x13FC, NONSEQ 0x1400, SEQ 0x1404; no burst crosses 0x1400.
- MAX_BEATS=4, len=40 (N=10) → NONSEQ issued at beats 0, 4, 8; last burst 2 beats INCR; o_beats_done=10.
- len=5 → N=2, two beats; len=1 → SINGLE NONSEQ one beat; len=0 → o_done 1 cycle after i_start, HTRANS stays IDLE.
- HREADY low 3 cycles on beat 2 → HADDR/HTRANS held stable, no extra o_rvalid, all data in order.
- ERROR on beat 3 of 8 (HREADY=0 then 1) → HTRANS=IDLE next cycle, o_error=1, o_done pulse, o_beats_done=2; HRESETn low mid-burst → all outputs at reset values immediately.
